straight_showdown_ctrl: RTL

STRAIGHT_SHOWDOWN_CTRL -- requirements
Module: straight_showdown_ctrl

---
 rtl/straight_showdown_ctrl_pkg.sv | 37 +++
 rtl/straight_showdown_ctrl_if.sv | 53 +++++
 rtl/straight_showdown_ctrl_straight_eval.sv | 44 ++++
 rtl/straight_showdown_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/straight_showdown_ctrl_pkg.sv
// Shared types and constants for the straight showdown controller.
package straight_showdown_ctrl_pkg;

  localparam int CARD_W = 4;

  typedef logic [CARD_W-1:0] card_t;

  // Ace is the top rank; a raw 0 on the inputs also means ace.
  localparam card_t ACE        = 4'd13;
  // Top card of the A-2-3-4-5 wheel.
  localparam card_t WHEEL_HIGH = 4'd4;

  // Winner encodings.
  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] P1   = 2'b01;
  localparam logic [1:0] P2   = 2'b10;
  localparam logic [1:0] TIE  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EVAL1 = 3'd1,
    EVAL2 = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Raw input 0 is an alternate ace code; everything else passes through.
  function automatic card_t capture_card(card_t n);
    return (n == '0) ? ACE : n;
  endfunction

  // Only 14 and 15 lie above the ace and are not valid cards.
  function automatic logic is_illegal(card_t n);
    return (n > ACE);
  endfunction

endpackage

// File: rtl/straight_showdown_ctrl_if.sv
// Request/result bundle for the straight showdown controller.
//
// Handshake: start is sampled only while busy is low (IDLE). Once accepted,
// busy stays high until the end of the single-cycle done pulse; start seen
// while busy is dropped, never queued. Results are valid on the done cycle
// and hold until the next evaluation overwrites them.
interface straight_showdown_ctrl_if;
  import straight_showdown_ctrl_pkg::*;

  logic   start;
  card_t  p1_card1_number;
  card_t  p1_card2_number;
  card_t  p2_card1_number;
  card_t  p2_card2_number;
  card_t  community_card1_number;
  card_t  community_card2_number;
  card_t  community_card3_number;
  card_t  community_card4_number;
  card_t  community_card5_number;

  logic       busy;
  logic       done;
  logic       p1_straight;
  logic       p2_straight;
  card_t      p1_max_num;
  card_t      p2_max_num;
  logic [1:0] winner;
  logic       err;
  state_t     dbg_state;

  modport master (
    output start,
    output p1_card1_number, p1_card2_number,
    output p2_card1_number, p2_card2_number,
    output community_card1_number, community_card2_number,
    output community_card3_number, community_card4_number,
    output community_card5_number,
    input  busy, done, p1_straight, p2_straight,
    input  p1_max_num, p2_max_num, winner, err, dbg_state
  );

  modport slave (
    input  start,
    input  p1_card1_number, p1_card2_number,
    input  p2_card1_number, p2_card2_number,
    input  community_card1_number, community_card2_number,
    input  community_card3_number, community_card4_number,
    input  community_card5_number,
    output busy, done, p1_straight, p2_straight,
    output p1_max_num, p2_max_num, winner, err, dbg_state
  );

endinterface

// File: rtl/straight_showdown_ctrl_straight_eval.sv
// Combinational straight finder over seven card numbers.
module straight_eval
  import straight_showdown_ctrl_pkg::*;
(
  input  card_t [6:0] nums,
  output logic        straight,
  output card_t       max_num,
  output logic        illegal
);

  logic [13:1] present;

  // Rank presence mask (duplicates collapse), then scan five-wide windows
  // from low to high so the last hit is the highest top card.
  always_comb begin
    present  = '0;
    illegal  = 1'b0;
    straight = 1'b0;
    max_num  = '0;
    for (int i = 0; i < 7; i++) begin
      if (is_illegal(nums[i])) illegal = 1'b1;
    end
    for (int v = 1; v <= 13; v++) begin
      for (int i = 0; i < 7; i++) begin
        if (nums[i] == card_t'(v)) present[v] = 1'b1;
      end
    end
    if (present[ACE] && (&present[4:1])) begin
      straight = 1'b1;
      max_num  = WHEEL_HIGH;
    end
    for (int t = 5; t <= 13; t++) begin
      if (&present[t -: 5]) begin
        straight = 1'b1;
        max_num  = card_t'(t);
      end
    end
    if (illegal) begin
      straight = 1'b0;
      max_num  = '0;
    end
  end

endmodule

// File: rtl/straight_showdown_ctrl.sv
// Two-player straight showdown: snapshot cards, evaluate each player with
// one shared evaluator, then compare.
module straight_showdown_ctrl
  import straight_showdown_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  straight_showdown_ctrl_if.slave bus
);

  state_t      state;
  card_t [1:0] snap_p1;
  card_t [1:0] snap_p2;
  card_t [4:0] snap_board;

  card_t [8:0] in_cards;
  logic        in_bad;
  card_t [6:0] ev_nums;
  logic        ev_straight;
  card_t       ev_max;
  logic        ev_illegal;

  assign in_cards = {bus.p1_card1_number, bus.p1_card2_number,
                     bus.p2_card1_number, bus.p2_card2_number,
                     bus.community_card1_number, bus.community_card2_number,
                     bus.community_card3_number, bus.community_card4_number,
                     bus.community_card5_number};

  assign bus.dbg_state = state;

  // Flag any illegal number in the live inputs so err is known at capture.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (is_illegal(in_cards[i])) in_bad = 1'b1;
    end
  end

  // Feed the shared evaluator: player 2 in EVAL2, player 1 otherwise.
  always_comb begin
    ev_nums = {snap_p1, snap_board};
    if (state == EVAL2) ev_nums = {snap_p2, snap_board};
  end

  straight_eval u_eval (
    .nums     (ev_nums),
    .straight (ev_straight),
    .max_num  (ev_max),
    .illegal  (ev_illegal)
  );

  // Sequencer with registered status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      snap_p1         <= '0;
      snap_p2         <= '0;
      snap_board      <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
      bus.p1_straight <= 1'b0;
      bus.p2_straight <= 1'b0;
      bus.p1_max_num  <= '0;
      bus.p2_max_num  <= '0;
      bus.winner      <= NONE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            snap_p1    <= {capture_card(bus.p1_card1_number),
                           capture_card(bus.p1_card2_number)};
            snap_p2    <= {capture_card(bus.p2_card1_number),
                           capture_card(bus.p2_card2_number)};
            snap_board <= {capture_card(bus.community_card1_number),
                           capture_card(bus.community_card2_number),
                           capture_card(bus.community_card3_number),
                           capture_card(bus.community_card4_number),
                           capture_card(bus.community_card5_number)};
            bus.err    <= in_bad;
            bus.busy   <= 1'b1;
            state      <= EVAL1;
          end
        end
        EVAL1: begin
          // An illegal card anywhere in the snapshot voids both hands.
          bus.p1_straight <= ev_straight & ~(bus.err | ev_illegal);
          bus.p1_max_num  <= (bus.err | ev_illegal) ? card_t'(0) : ev_max;
          state           <= EVAL2;
        end
        EVAL2: begin
          bus.p2_straight <= ev_straight & ~(bus.err | ev_illegal);
          bus.p2_max_num  <= (bus.err | ev_illegal) ? card_t'(0) : ev_max;
          state           <= CMP;
        end
        CMP: begin
          if (bus.p1_straight && bus.p2_straight) begin
            if (bus.p1_max_num > bus.p2_max_num)      bus.winner <= P1;
            else if (bus.p1_max_num < bus.p2_max_num) bus.winner <= P2;
            else                                      bus.winner <= TIE;
          end else if (bus.p1_straight) begin
            bus.winner <= P1;
          end else if (bus.p2_straight) begin
            bus.winner <= P2;
          end else begin
            bus.winner <= NONE;
          end
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
